fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequences instruction fetch for the core: owns the architectural instruction pointer, drives a 16-bit-word instruction-memory port with a req/ready handshake, and assembles opcode plus optional immediate word into one 32-bit instruction. It hands each instruction to decode over a valid/ready handshake. It accepts branch/jump redirects computed downstream by the next-pointer logic, so it is the stateful front end around that combinational branch evaluation.

## Interface
- RESET_PC, 16'h0000, instruction pointer loaded on reset
- IMM_BIT, 11, bit of the opcode word flagging a following immediate word (imm_valid)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  fetch request, registered
- mem_addr  out  16  word address of the fetch, registered, stable while mem_req && !mem_ready
- mem_ready  in  1  memory accepts request; mem_rdata valid in the same cycle
- mem_rdata  in  16  fetched word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts instruction
- out_instr  out  32  {opcode word, immediate word}; low half 16'h0000 when no immediate
- out_pc  out  16  address of the opcode word
- out_next_pc  out  16  sequential successor: out_pc+1, or out_pc+2 with immediate
- redirect_valid  in  1  taken branch/jump; flush and refetch
- redirect_addr  in  16  redirect target
- halt  in  1  stop starting new fetches while high

## Operation
- States: FETCH_OP, FETCH_IMM, ISSUE, IDLE.
- FETCH_OP: mem_req=1, mem_addr=pc. On mem_ready, latch opcode. If opcode[IMM_BIT], go to FETCH_IMM at pc+1; else go to ISSUE with imm=0.
- FETCH_IMM: mem_req=1, mem_addr=pc+1. On mem_ready, latch immediate and go to ISSUE.
- ISSUE: out_valid=1. On out_ready, pc <= out_next_pc. Next state is IDLE if halt, else FETCH_OP.
- IDLE: mem_req=0. When halt is low, go to FETCH_OP next cycle.
- Redirect (highest priority) when redirect_valid is high in any state:
  - pc <= redirect_addr.
  - Any latched opcode or immediate is discarded.
  - out_valid is combinationally forced to 0 in that cycle (out_valid = state==ISSUE && !redirect_valid), so no instruction issues in the redirect cycle.
- A request that is open (mem_req=1, mem_ready=0) is never withdrawn or re-addressed. A redirect during it sets flush_pending. The returning word is dropped, and the next request uses the redirect address.
- Redirect with mem_ready in the same cycle: word dropped, next state FETCH_OP at redirect_addr.
- Redirect during IDLE with halt high: pc updated, remain IDLE.
- All address arithmetic is 16-bit modulo:
  - 0xFFFF+1 = 0x0000, so an immediate of an opcode at 0xFFFF is fetched from 0x0000.
  - out_next_pc wraps likewise.
- halt does not abort an open request or a pending ISSUE. It only blocks the FETCH_OP entry.

## Timing
- Reset values: state=FETCH_OP, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=RESET_PC, out_next_pc=RESET_PC+1, flush_pending=0.
- First mem_req=1 is in the first clock edge after rst deasserts.
- Zero-wait memory:
  - Instruction without immediate: 2 cycles per instruction (FETCH_OP, ISSUE).
  - Instruction with immediate: 3 cycles.
- Redirect to first mem_req at the target: 1 cycle.
- out_* hold stable from out_valid rise until the out_ready handshake, except for a redirect flush.
- rst mid-operation clears everything immediately; open memory handshakes are abandoned.

## Configuration
- FETCH_SEQ_PERF_EN defined: adds outputs perf_issued[31:0] and perf_stall[31:0], both reset to 0.
  - perf_issued increments on each out_valid && out_ready.
  - perf_stall increments each cycle with mem_req && !mem_ready.
  - Both saturate at 32'hFFFF_FFFF.
  - A redirect clears neither.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset release, RESET_PC=0x0010, memory always ready, words 0x1000, 0x2000: mem_addr 0x0010 then 0x0011; out_instr 0x10000000, out_pc 0x0010, out_next_pc 0x0011.
- Opcode 0x0800 (IMM_BIT set) at 0x0020, immediate 0xBEEF: out_instr 0x0800BEEF, out_next_pc 0x0022, 3 cycles total.
- Redirect to 0x0100 while a request to 0x0030 waits 3 cycles on mem_ready: mem_addr stays 0x0030 until ready, the word is dropped, next mem_addr is 0x0100, and no out_valid occurs for 0x0030.
- Redirect in ISSUE with out_ready high: out_valid=0 that cycle, no issue, next fetch at the target.
- Opcode with immediate at 0xFFFF: immediate fetched from 0x0000, out_next_pc 0x0001.
- halt high during ISSUE: instruction issues, then IDLE with mem_req=0; halt low gives mem_req=1 one cycle later. With FETCH_SEQ_PERF_EN, perf_issued counts exactly the handshakes.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, fetches opcode (+ optional immediate) over a req/ready port, issues {opcode, imm} to decode.
// Zero-wait: 2 cycles per plain instruction, 3 with immediate; FETCH_SEQ_PERF_EN adds saturating issue/stall counters.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IMM_BIT  = 11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic [15:0] i_mem_rdata,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [15:0] o_out_pc,
    output logic [15:0] o_out_next_pc,
    input  logic        i_redirect_valid,
    input  logic [15:0] i_redirect_addr,
    input  logic        i_halt
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0] o_perf_issued,
    output logic [31:0] o_perf_stall
`endif
);

    typedef enum logic [1:0] {FETCH_OP, FETCH_IMM, ISSUE, IDLE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic        r_mem_req;
    logic [15:0] r_mem_addr;
    logic        r_flush_pending;
    logic [15:0] r_opcode;
    logic [15:0] r_imm;
    logic        r_has_imm;

    logic        w_mem_fire;
    logic        w_mem_open;
    logic        w_drop;
    logic        w_issue_fire;
    logic [15:0] w_next_pc;
    logic [15:0] w_pc_nxt;
    logic        w_mem_req_nxt;
    logic [15:0] w_mem_addr_nxt;

    assign w_mem_fire   = r_mem_req & i_mem_ready;
    assign w_mem_open   = r_mem_req & ~i_mem_ready;
    assign w_drop       = r_flush_pending | i_redirect_valid;
    assign w_issue_fire = o_out_valid & i_out_ready;
    assign w_next_pc    = r_pc + (r_has_imm ? 16'd2 : 16'd1);
    assign w_pc_nxt     = i_redirect_valid ? i_redirect_addr :
                          (w_issue_fire ? w_next_pc : r_pc);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= FETCH_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH_OP: begin
                if (w_mem_fire && !w_drop) begin
                    w_state_nxt = i_mem_rdata[IMM_BIT] ? FETCH_IMM : ISSUE;
                end
            end
            FETCH_IMM: begin
                if (w_mem_fire) begin
                    w_state_nxt = w_drop ? FETCH_OP : ISSUE;
                end
            end
            ISSUE: begin
                if (i_redirect_valid || i_out_ready) begin
                    w_state_nxt = i_halt ? IDLE : FETCH_OP;
                end
            end
            IDLE: begin
                if (!i_halt) begin
                    w_state_nxt = FETCH_OP;
                end
            end
            default: w_state_nxt = FETCH_OP;
        endcase
    end

    // An open request keeps its address even when a redirect moves the PC underneath it.
    always_comb begin
        o_out_valid    = (r_state == ISSUE) && !i_redirect_valid;
        w_mem_req_nxt  = (w_state_nxt == FETCH_OP) || (w_state_nxt == FETCH_IMM);
        w_mem_addr_nxt = (w_state_nxt == FETCH_IMM) ? (w_pc_nxt + 16'd1) : w_pc_nxt;
        if (w_mem_open) begin
            w_mem_addr_nxt = r_mem_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc            <= RESET_PC;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= RESET_PC;
            r_flush_pending <= 1'b0;
            r_opcode        <= 16'h0000;
            r_imm           <= 16'h0000;
            r_has_imm       <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            if (w_mem_fire) begin
                r_flush_pending <= 1'b0;
            end else if (i_redirect_valid && w_mem_open) begin
                r_flush_pending <= 1'b1;
            end
            if (i_redirect_valid) begin
                r_opcode  <= 16'h0000;
                r_imm     <= 16'h0000;
                r_has_imm <= 1'b0;
            end else if (w_mem_fire && !r_flush_pending) begin
                if (r_state == FETCH_OP) begin
                    r_opcode  <= i_mem_rdata;
                    r_imm     <= 16'h0000;
                    r_has_imm <= i_mem_rdata[IMM_BIT];
                end else if (r_state == FETCH_IMM) begin
                    r_imm <= i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_out_instr   = {r_opcode, r_imm};
    assign o_out_pc      = r_pc;
    assign o_out_next_pc = w_next_pc;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_issued <= 32'd0;
            r_perf_stall  <= 32'd0;
        end else begin
            if (w_issue_fire && (r_perf_issued != 32'hFFFF_FFFF)) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (w_mem_open && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_issued = r_perf_issued;
    assign o_perf_stall  = r_perf_stall;
`else
    // Default build carries no counters.
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: expected fetch addresses and issued instructions are queued as stimulus is applied.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
        logic [15:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_next_pc;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        halt;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;
    int n_issue_exp = 0;
    int mem_wait = 0;
    int wait_left = 0;
    bit armed = 1'b0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] fetch_q [$];
    exp_t        issue_q [$];
    int          issue_cyc_q [$];

    fetch_sequencer #(.RESET_PC(16'h0010), .IMM_BIT(11)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_mem_req        (mem_req),
        .o_mem_addr       (mem_addr),
        .i_mem_ready      (mem_ready),
        .i_mem_rdata      (mem_rdata),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_instr      (out_instr),
        .o_out_pc         (out_pc),
        .o_out_next_pc    (out_next_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_addr  (redirect_addr),
        .i_halt           (halt)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .o_perf_issued    (perf_issued),
        .o_perf_stall     (perf_stall)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h5000 | {5'b0, a[10:0]};
    endfunction

    task automatic push_fetch(input logic [15:0] a);
        fetch_q.push_back(a);
    endtask

    task automatic push_issue(input logic [31:0] instr, input logic [15:0] pc, input logic [15:0] npc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.npc   = npc;
        issue_q.push_back(e);
        n_issue_exp++;
    endtask

    // One clock: memory model drives ready/rdata, scoreboard checks handshakes, then the edge.
    task automatic cyc();
        logic [15:0] ea;
        exp_t        e;
        if (!mem_req) begin
            mem_ready = 1'b0;
            armed     = 1'b0;
        end else begin
            if (!armed) begin
                wait_left = mem_wait;
                armed     = 1'b1;
            end
            if (wait_left > 0) begin
                mem_ready = 1'b0;
                wait_left--;
            end else begin
                mem_ready = 1'b1;
                armed     = 1'b0;
            end
        end
        mem_rdata = rd(mem_addr);
        #1;
        if (mem_req && mem_ready) begin
            if (fetch_q.size() == 0) begin
                check("fetch_unexpected", 32'(fetch_q.size()), 32'd1);
            end else begin
                ea = fetch_q.pop_front();
                check("fetch_addr", 32'(mem_addr), 32'(ea));
            end
        end
        if (out_valid && out_ready) begin
            issue_cyc_q.push_back(cyc_n);
            if (issue_q.size() == 0) begin
                check("issue_unexpected", 32'(issue_q.size()), 32'd1);
            end else begin
                e = issue_q.pop_front();
                check("issue_instr", out_instr, e.instr);
                check("issue_pc", 32'(out_pc), 32'(e.pc));
                check("issue_next_pc", 32'(out_next_pc), 32'(e.npc));
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drain();
        int n = 0;
        while ((issue_q.size() != 0 || fetch_q.size() != 0) && n < 40) begin
            cyc();
            n++;
        end
        if (issue_q.size() != 0 || fetch_q.size() != 0) begin
            check("drain_timeout", 32'(issue_q.size() + fetch_q.size()), 32'd0);
            issue_q.delete();
            fetch_q.delete();
        end
    endtask

    initial begin
        int base;
        rst = 1'b1; halt = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_addr = 16'h0000;
        mem_ready = 1'b0; mem_rdata = 16'h0000;
        mem[16'h0010] = 16'h1000; mem[16'h0011] = 16'h2000;
        mem[16'h0020] = 16'h0800; mem[16'h0021] = 16'hBEEF;
        mem[16'h0030] = 16'h3000; mem[16'h0100] = 16'h1234;
        mem[16'hFFFF] = 16'h0801; mem[16'h0000] = 16'hCAFE;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0010);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'h0010);
        check("rst_out_next_pc", 32'(out_next_pc), 32'h0011);

        // Reset release with halt held: exactly one instruction, then IDLE.
        push_fetch(16'h0010);
        push_issue(32'h1000_0000, 16'h0010, 16'h0011);
        rst = 1'b0;
        cyc();
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", 32'(mem_addr), 32'h0010);
        cyc();
        check("issue_valid", 32'(out_valid), 32'd1);
        cyc();
        check("halt_idle_req", 32'(mem_req), 32'd0);
        cyc();
        check("halt_idle_req2", 32'(mem_req), 32'd0);

        // Dropping halt for one cycle resumes fetch at the next PC.
        push_fetch(16'h0011);
        push_issue(32'h2000_0000, 16'h0011, 16'h0012);
        halt = 1'b0;
        cyc();
        check("resume_req", 32'(mem_req), 32'd1);
        check("resume_addr", 32'(mem_addr), 32'h0011);
        halt = 1'b1;
        drain();

        // Redirect from IDLE into a stream: imm instruction then two plain ones.
        push_fetch(16'h0020); push_fetch(16'h0021); push_fetch(16'h0022); push_fetch(16'h0023);
        push_issue(32'h0800_BEEF, 16'h0020, 16'h0022);
        push_issue(32'h5022_0000, 16'h0022, 16'h0023);
        push_issue(32'h5023_0000, 16'h0023, 16'h0024);
        redirect_valid = 1'b1; redirect_addr = 16'h0020; halt = 1'b0;
        cyc();
        redirect_valid = 1'b0;
        check("redir_idle_addr", 32'(mem_addr), 32'h0020);
        issue_cyc_q.delete();
        base = cyc_n;
        for (int i = 0; i < 7; i++) begin
            halt = (i == 6);
            cyc();
        end
        check("timing_cnt", 32'(issue_cyc_q.size()), 32'd3);
        if (issue_cyc_q.size() == 3) begin
            check("imm_latency", 32'(issue_cyc_q[0] - base), 32'd2);
            check("gap_plain1", 32'(issue_cyc_q[1] - issue_cyc_q[0]), 32'd2);
            check("gap_plain2", 32'(issue_cyc_q[2] - issue_cyc_q[1]), 32'd2);
        end
        drain();
        check("stream_idle_req", 32'(mem_req), 32'd0);

        // Redirect while a request waits on memory: address holds, word dropped.
        push_fetch(16'h0030); push_fetch(16'h0100);
        push_issue(32'h1234_0000, 16'h0100, 16'h0101);
        redirect_valid = 1'b1; redirect_addr = 16'h0030; halt = 1'b0; mem_wait = 3;
        cyc();
        check("wait_addr0", 32'(mem_addr), 32'h0030);
        redirect_addr = 16'h0100; halt = 1'b1;
        cyc();
        mem_wait = 0; redirect_valid = 1'b0;
        check("wait_hold1", 32'(mem_addr), 32'h0030);
        check("wait_req1", 32'(mem_req), 32'd1);
        cyc();
        check("wait_hold2", 32'(mem_addr), 32'h0030);
        cyc();
        check("wait_hold3", 32'(mem_addr), 32'h0030);
        cyc();
        check("flush_req", 32'(mem_req), 32'd1);
        check("flush_addr", 32'(mem_addr), 32'h0100);
        drain();

        // Redirect arriving in ISSUE with decode ready: nothing issues.
        push_fetch(16'h0101); push_fetch(16'h0200);
        push_issue(32'h5200_0000, 16'h0200, 16'h0201);
        halt = 1'b0;
        cyc();
        halt = 1'b1;
        cyc();
        check("pre_redir_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1; redirect_addr = 16'h0200; halt = 1'b0;
        #1;
        check("redir_issue_valid", 32'(out_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0; halt = 1'b1;
        check("redir_issue_req", 32'(mem_req), 32'd1);
        check("redir_issue_addr", 32'(mem_addr), 32'h0200);
        drain();

        // Immediate at 0xFFFF wraps to 0x0000; outputs hold while decode stalls.
        push_fetch(16'hFFFF); push_fetch(16'h0000);
        push_issue(32'h0801_CAFE, 16'hFFFF, 16'h0001);
        redirect_valid = 1'b1; redirect_addr = 16'hFFFF; halt = 1'b0;
        cyc();
        redirect_valid = 1'b0; halt = 1'b1; out_ready = 1'b0;
        cyc();
        check("wrap_imm_addr", 32'(mem_addr), 32'h0000);
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_instr", out_instr, 32'h0801_CAFE);
            check("stall_next_pc", 32'(out_next_pc), 32'h0001);
            cyc();
        end
        out_ready = 1'b1;
        drain();

        check("sb_issue_left", 32'(issue_q.size()), 32'd0);
`ifdef FETCH_SEQ_PERF_EN
        check("perf_issued", perf_issued, 32'(n_issue_exp));
`endif

        // Reset in the middle of an open request clears everything at once.
        halt = 1'b0;
        cyc();
        check("pre_rst_req", 32'(mem_req), 32'd1);
        check("pre_rst_addr", 32'(mem_addr), 32'h0001);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'h0010);
        check("mid_rst_pc", 32'(out_pc), 32'h0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
